// File: rtl/sram4k8_dma.sv
// sram4k8_dma: fill/copy block-transfer engine in front of a 4Kx8 work SRAM.
// The CPU bus is passed straight through to the SRAM while the engine is idle.
// Ports:
//   i_MCLK, i_RST_n               clock, async active-low reset
//   i_START, i_MODE               command strobe, 0=fill / 1=copy
//   i_SRC, i_DST, i_LEN, i_FILL   command operands
//   o_BUSY, o_DONE, o_CPU_WAIT    status; CPU stall equals busy
//   i_CPU_*                       CPU bus side
//   o_RAM_*, i_RAM_DOUT           SRAM side (synchronous strobes)
// Optional macro SRAM4K8_DMA_IRQ_EN adds o_IRQ_n / i_IRQ_ACK.
module sram4k8_dma #(
    parameter int AW = 12,
    parameter int LW = 13
) (
    input  logic          i_MCLK,
    input  logic          i_RST_n,
    input  logic          i_START,
    input  logic          i_MODE,
    input  logic [AW-1:0] i_SRC,
    input  logic [AW-1:0] i_DST,
    input  logic [LW-1:0] i_LEN,
    input  logic [7:0]    i_FILL,
    output logic          o_BUSY,
    output logic          o_DONE,
    input  logic [AW-1:0] i_CPU_ADDR,
    input  logic [7:0]    i_CPU_DIN,
    input  logic          i_CPU_WR_n,
    input  logic          i_CPU_RD_n,
    output logic          o_CPU_WAIT,
    output logic [AW-1:0] o_RAM_ADDR,
    output logic [7:0]    o_RAM_DIN,
    output logic          o_RAM_WR_n,
    output logic          o_RAM_RD_n,
    input  logic [7:0]    i_RAM_DOUT
`ifdef SRAM4K8_DMA_IRQ_EN
    ,
    output logic          o_IRQ_n,
    input  logic          i_IRQ_ACK
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CP_RD,
        S_CP_WR,
        S_FIN
    } state_t;

    localparam logic [AW-1:0] A_ONE = AW'(1);
    localparam logic [LW-1:0] L_ONE = LW'(1);

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] cnt;
    logic [7:0]    fill;
    logic          last;

    // The job mode is carried by the state itself (FILL vs CP_*),
    // so it needs no separate register after the start cycle.
    assign last = (cnt == L_ONE);

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (i_START) begin
                    if (i_LEN == '0)
                        state_n = S_FIN;
                    else if (i_MODE)
                        state_n = S_CP_RD;
                    else
                        state_n = S_FILL;
                end
            end
            S_FILL:  if (last) state_n = S_FIN;
            S_CP_RD: state_n = S_CP_WR;
            S_CP_WR: state_n = last ? S_FIN : S_CP_RD;
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            src  <= '0;
            dst  <= '0;
            cnt  <= '0;
            fill <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_START) begin
                        src  <= i_SRC;
                        dst  <= i_DST;
                        cnt  <= i_LEN;
                        fill <= i_FILL;
                    end
                end
                S_FILL: begin
                    dst <= dst + A_ONE;
                    cnt <= cnt - L_ONE;
                end
                S_CP_WR: begin
                    src <= src + A_ONE;
                    dst <= dst + A_ONE;
                    cnt <= cnt - L_ONE;
                end
                default: ;
            endcase
        end
    end

    // SRAM side: CPU owns the bus only in IDLE; otherwise its strobes
    // are dropped so nothing it does can reach the array.
    always_comb begin
        o_RAM_ADDR = i_CPU_ADDR;
        o_RAM_DIN  = i_CPU_DIN;
        o_RAM_WR_n = i_CPU_WR_n;
        o_RAM_RD_n = i_CPU_RD_n;
        unique case (state)
            S_FILL: begin
                o_RAM_ADDR = dst;
                o_RAM_DIN  = fill;
                o_RAM_WR_n = 1'b0;
                o_RAM_RD_n = 1'b1;
            end
            S_CP_RD: begin
                o_RAM_ADDR = src;
                o_RAM_DIN  = 8'h00;
                o_RAM_WR_n = 1'b1;
                o_RAM_RD_n = 1'b0;
            end
            S_CP_WR: begin
                o_RAM_ADDR = dst;
                o_RAM_DIN  = i_RAM_DOUT;
                o_RAM_WR_n = 1'b0;
                o_RAM_RD_n = 1'b1;
            end
            S_FIN: begin
                o_RAM_ADDR = dst;
                o_RAM_DIN  = 8'h00;
                o_RAM_WR_n = 1'b1;
                o_RAM_RD_n = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_BUSY     = (state != S_IDLE);
    assign o_DONE     = (state == S_FIN);
    assign o_CPU_WAIT = o_BUSY;

`ifdef SRAM4K8_DMA_IRQ_EN
    // Completion beats a coincident acknowledge.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n)
            o_IRQ_n <= 1'b1;
        else if (state == S_FIN)
            o_IRQ_n <= 1'b0;
        else if (i_IRQ_ACK)
            o_IRQ_n <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sram4k8_dma.sv
// tb_sram4k8_dma: random and directed jobs against a job-level model
// of the fill/copy engine and a behavioural 4Kx8 SRAM.
module tb_sram4k8_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [11:0] src = '0;
    logic [11:0] dst = '0;
    logic [12:0] len = '0;
    logic [7:0]  fill = '0;
    logic        busy, done, cpu_wait;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic        cpu_wr_n = 1'b1;
    logic        cpu_rd_n = 1'b1;
    logic [11:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_wr_n, ram_rd_n;
    logic [7:0]  ram_dout;
`ifdef SRAM4K8_DMA_IRQ_EN
    logic        irq_n;
    logic        irq_ack = 1'b0;
`endif

    sram4k8_dma dut (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_START(start), .i_MODE(mode),
        .i_SRC(src), .i_DST(dst), .i_LEN(len), .i_FILL(fill),
        .o_BUSY(busy), .o_DONE(done),
        .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din),
        .i_CPU_WR_n(cpu_wr_n), .i_CPU_RD_n(cpu_rd_n),
        .o_CPU_WAIT(cpu_wait),
        .o_RAM_ADDR(ram_addr), .o_RAM_DIN(ram_din),
        .o_RAM_WR_n(ram_wr_n), .o_RAM_RD_n(ram_rd_n),
        .i_RAM_DOUT(ram_dout)
`ifdef SRAM4K8_DMA_IRQ_EN
        , .o_IRQ_n(irq_n), .i_IRQ_ACK(irq_ack)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural synchronous SRAM.
    logic [7:0] mem [4096];
    always @(posedge clk) begin
        if (!ram_wr_n) mem[ram_addr] <= ram_din;
        if (!ram_rd_n) ram_dout <= mem[ram_addr];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Job-level model: cycles of BUSY still to come, and the queue of
    // writes the job must perform, derived from the final byte contents.
    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        exp_q[$];
    int         m_left = 0;
    logic [7:0] ref_mem [4096];
    logic [7:0] scr [4096];

    always @(negedge clk) begin
        wr_t w;
        if (!rst_n) begin
            m_left = 0;
            exp_q.delete();
        end
        chk(busy == (m_left > 0), "busy", int'(busy), int'(m_left > 0));
        chk(done == (m_left == 1), "done", int'(done), int'(m_left == 1));
        chk(cpu_wait == (m_left > 0), "cpu_wait", int'(cpu_wait), int'(m_left > 0));
        if (m_left == 0) begin
            chk(ram_addr == cpu_addr && ram_din == cpu_din &&
                ram_wr_n == cpu_wr_n && ram_rd_n == cpu_rd_n, "passthru",
                int'({ram_addr, ram_din, ram_wr_n, ram_rd_n}),
                int'({cpu_addr, cpu_din, cpu_wr_n, cpu_rd_n}));
        end else begin
            if (!ram_wr_n) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_write", int'(ram_addr), 0);
                end else begin
                    w = exp_q.pop_front();
                    chk(ram_addr == w.a && ram_din == w.d, "dma_write",
                        int'({ram_addr, ram_din}), int'({w.a, w.d}));
                    ref_mem[w.a] = w.d;
                end
            end
            if (m_left == 1)
                chk(exp_q.size() == 0, "writes_left", exp_q.size(), 0);
        end
        if (rst_n) begin
            if (m_left > 0) begin
                m_left--;
            end else begin
                if (!cpu_wr_n) ref_mem[cpu_addr] = cpu_din;
                if (start) begin
                    int n;
                    n = int'(len);
                    scr = ref_mem;
                    for (int i = 0; i < n; i++) begin
                        wr_t x;
                        x.a = 12'((int'(dst) + i) % 4096);
                        x.d = mode ? scr[(int'(src) + i) % 4096] : fill;
                        scr[x.a] = x.d;
                        exp_q.push_back(x);
                    end
                    m_left = (n == 0) ? 1 : (mode ? 2 * n + 1 : n + 1);
                end
            end
        end
    end

    task automatic wait_done(output int bc, output int dc);
        bc = 0;
        dc = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) dc++;
            if (!busy) break;
        end
    endtask

    task automatic kick(input bit m, input int s, input int d,
                        input int l, input logic [7:0] f);
        @(posedge clk);
        #1;
        start = 1'b1;
        mode = m;
        src = 12'(s);
        dst = 12'(d);
        len = 13'(l);
        fill = f;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_job(input bit m, input int s, input int d,
                           input int l, input logic [7:0] f,
                           output int bc, output int dc);
        kick(m, s, d, l, f);
        wait_done(bc, dc);
    endtask

    task automatic cpu_wr(input int a, input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu_addr = 12'(a);
        cpu_din = d;
        cpu_wr_n = 1'b0;
        @(posedge clk);
        #1;
        cpu_wr_n = 1'b1;
    endtask

    initial begin
        int bc, dc, bad, nl;
        bit m;
        repeat (3) @(posedge clk);
        #1;
        chk(busy == 1'b0 && done == 1'b0, "reset_state", int'({busy, done}), 0);
`ifdef SRAM4K8_DMA_IRQ_EN
        chk(irq_n == 1'b1, "irq_reset", int'(irq_n), 1);
`endif
        rst_n = 1'b1;

        run_job(1'b0, 0, 12'h000, 4096, 8'hA5, bc, dc);
        chk(bc == 4097, "fill_busy", bc, 4097);
        chk(dc == 1, "fill_done", dc, 1);
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] != 8'hA5) bad++;
        chk(bad == 0, "fill_all_a5", bad, 0);
`ifdef SRAM4K8_DMA_IRQ_EN
        chk(irq_n == 1'b0, "irq_low", int'(irq_n), 0);
        @(posedge clk);
        #1 irq_ack = 1'b1;
        @(posedge clk);
        #1 irq_ack = 1'b0;
        chk(irq_n == 1'b1, "irq_ack", int'(irq_n), 1);
`endif

        run_job(1'b0, 0, 12'hFFE, 4, 8'h3C, bc, dc);
        chk(mem[12'hFFE] == 8'h3C && mem[12'hFFF] == 8'h3C &&
            mem[12'h000] == 8'h3C && mem[12'h001] == 8'h3C, "wrap_fill",
            int'({mem[12'hFFE], mem[12'h001]}), 16'h3C3C);
        chk(mem[12'h002] == 8'hA5, "wrap_untouched", int'(mem[12'h002]), 8'hA5);

        for (int i = 0; i < 16; i++) cpu_wr(12'h100 + i, 8'(i));
        run_job(1'b1, 12'h100, 12'h800, 16, 8'h00, bc, dc);
        chk(bc == 33, "copy_busy", bc, 33);
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[12'h800 + i] != 8'(i)) bad++;
        chk(bad == 0, "copy_data", bad, 0);

        cpu_wr(12'h200, 8'h11);
        cpu_wr(12'h201, 8'h22);
        run_job(1'b1, 12'h200, 12'h202, 6, 8'h00, bc, dc);
        chk({mem[12'h202], mem[12'h203], mem[12'h204],
             mem[12'h205], mem[12'h206], mem[12'h207]} == 48'h112211221122,
            "overlap", int'({mem[12'h202], mem[12'h207]}), 16'h1122);

        run_job(1'b0, 0, 12'h500, 0, 8'h5A, bc, dc);
        chk(bc == 1 && dc == 1, "len0", int'({bc[7:0], dc[7:0]}), 16'h0101);
        chk(mem[12'h500] == 8'hA5, "len0_nowrite", int'(mem[12'h500]), 8'hA5);

        kick(1'b0, 0, 12'h300, 20, 8'h77);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        mode = 1'b1;
        src = 12'h800;
        dst = 12'h330;
        len = 13'd5;
        cpu_addr = 12'h320;
        cpu_din = 8'h99;
        cpu_wr_n = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 cpu_wr_n = 1'b1;
        wait_done(bc, dc);
        chk(dc == 1, "busy_start_done", dc, 1);
        chk(mem[12'h330] == 8'hA5, "start_ignored", int'(mem[12'h330]), 8'hA5);
        chk(mem[12'h320] == 8'hA5, "cpu_blocked", int'(mem[12'h320]), 8'hA5);
        chk(mem[12'h313] == 8'h77, "busy_fill_end", int'(mem[12'h313]), 8'h77);

        kick(1'b0, 0, 12'h400, 100, 8'hEE);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk(busy == 1'b0 && done == 1'b0 && ram_wr_n == cpu_wr_n,
            "abort_idle", int'({busy, done, ram_wr_n}), 1);
        dc = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk(dc == 0, "abort_no_done", dc, 0);
`ifdef SRAM4K8_DMA_IRQ_EN
        chk(irq_n == 1'b1, "irq_after_rst", int'(irq_n), 1);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) if (mem[12'h400 + i] == 8'hEE) bad++;
        chk(bad == 5, "abort_bytes", bad, 5);

        for (int j = 0; j < 40; j++) begin
            repeat ($urandom_range(0, 3))
                cpu_wr($urandom_range(0, 4095), 8'($urandom));
            @(posedge clk);
            #1 cpu_rd_n = 1'($urandom);
            cpu_addr = 12'($urandom);
            m = 1'($urandom);
            nl = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 300)
                                               : $urandom_range(0, 40);
            run_job(m, $urandom_range(0, 4095), $urandom_range(0, 4095),
                    nl, 8'($urandom), bc, dc);
            chk(bc == ((nl == 0) ? 1 : (m ? 2 * nl + 1 : nl + 1)),
                "rand_busy", bc, (nl == 0) ? 1 : (m ? 2 * nl + 1 : nl + 1));
            cpu_rd_n = 1'b1;
        end

        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] != ref_mem[i]) bad++;
        chk(bad == 0, "final_image", bad, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
